mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 4:1 mux datapath between NUM_REQ requesters. Each requester presents its beat on its mux input (a/b/c/d) and raises req. The arbiter drives the mux sel/valid, acknowledges each accepted beat, and caps consecutive beats per owner at MAX_BURST to guarantee fairness. It sits directly in front of the mux; the mux output goes to a downstream consumer with an out_ready handshake.

---
 rtl/mux_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 35 +++
 rtl/mux_rr_arbiter.sv | 118 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and default sizing for the round-robin mux arbiter.
// Imported by the priority picker and the arbiter top.
package mux_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: returns the first requester at or after rr_ptr,
// wrapping modulo NUM_REQ.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int SEL_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   rr_ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  int               sum_s;
  logic [SEL_W-1:0] pos_s;
  logic             hit_s;

  // Scan every position once, starting at rr_ptr; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum_s = 0;
    pos_s = '0;
    hit_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s = int'(rr_ptr) + k;
      pos_s = (sum_s >= NUM_REQ) ? SEL_W'(sum_s - NUM_REQ) : SEL_W'(sum_s);
      hit_s = ~found & req[pos_s];
      idx   = hit_s ? pos_s : idx;
      found = found | hit_s;
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select/valid of a shared N:1 mux, with a
// per-owner burst cap so that no requester can starve the others.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int NUM_REQ   = DEF_NUM_REQ,
  parameter  int MAX_BURST = DEF_MAX_BURST,
  localparam int SEL_W     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] ack,
  output logic [SEL_W-1:0]   sel,
  output logic               valid,
  output logic               busy
);

  localparam int               CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] BURST_CAP = CNT_W'(MAX_BURST);

  arb_state_e       state_r;
  logic [SEL_W-1:0] rr_ptr_r;
  logic [CNT_W-1:0] burst_cnt_r;

  logic             owner_req_s;
  logic             xfer_s;
  logic             keep_s;
  logic             release_s;
  logic             found_s;
  logic [SEL_W-1:0] pick_idx_s;
  logic [SEL_W-1:0] pick_ptr_s;
  logic [SEL_W-1:0] next_ptr_s;
  logic [CNT_W-1:0] burst_nxt_s;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  // One picker serves both paths: from rr_ptr when idle, from owner+1 on handover.
  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req   (req),
    .rr_ptr(pick_ptr_s),
    .found (found_s),
    .idx   (pick_idx_s)
  );

  // Handshake, burst accounting and release decision for the current owner.
  always_comb begin
    owner_req_s = req[sel];
    // A beat presented during reset is abandoned, so it is never acknowledged.
    valid       = busy & owner_req_s & ~reset;
    xfer_s      = valid & out_ready;
    ack         = gnt & {NUM_REQ{xfer_s}};
    burst_nxt_s = burst_cnt_r + CNT_W'(1);
    keep_s      = xfer_s & (burst_nxt_s < BURST_CAP);
    release_s   = busy & ((xfer_s & ~keep_s) | ~owner_req_s);
    next_ptr_s  = (sel == LAST_IDX) ? '0 : sel + SEL_W'(1);
    pick_ptr_s  = busy ? next_ptr_s : rr_ptr_r;
  end

  // Arbitration FSM with registered grant, select and busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      gnt         <= '0;
      sel         <= '0;
      busy        <= 1'b0;
      rr_ptr_r    <= '0;
      burst_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            state_r     <= BUSY;
            gnt         <= onehot(pick_idx_s);
            sel         <= pick_idx_s;
            busy        <= 1'b1;
            burst_cnt_r <= '0;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (release_s) begin
            rr_ptr_r    <= next_ptr_s;
            burst_cnt_r <= '0;
            // Owner sits at lowest priority, so re-granting it needs no bubble.
            if (found_s) begin
              gnt <= onehot(pick_idx_s);
              sel <= pick_idx_s;
            end else begin
              state_r <= IDLE;
              gnt     <= '0;
              busy    <= 1'b0;
            end
          end else if (xfer_s) begin
            burst_cnt_r <= burst_nxt_s;
          end else begin
            burst_cnt_r <= burst_cnt_r;
          end
        end
        default: begin
          state_r     <= IDLE;
          gnt         <= '0;
          busy        <= 1'b0;
          burst_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed, table-driven bench for mux_rr_arbiter (NUM_REQ=4, MAX_BURST=4).
// Each table row is one clock cycle: inputs driven after the rising edge, outputs sampled at the falling edge.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       out_ready;
  logic [3:0] gnt;
  logic [3:0] ack;
  logic [1:0] sel;
  logic       valid;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic       ordy;
    logic       chk;
    logic       sel_dc;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic [3:0] ack;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  mux_rr_arbiter #(
    .NUM_REQ  (4),
    .MAX_BURST(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .out_ready(out_ready),
    .gnt      (gnt),
    .ack      (ack),
    .sel      (sel),
    .valid    (valid),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic void add(input logic rst, input logic [3:0] r, input logic o,
                              input logic chk, input logic sdc, input logic [3:0] g,
                              input logic [1:0] s, input logic v, input logic [3:0] a,
                              input logic b);
    vec_t t;
    t.rst = rst; t.req = r; t.ordy = o; t.chk = chk; t.sel_dc = sdc;
    t.gnt = g; t.sel = s; t.valid = v; t.ack = a; t.busy = b;
    vecs.push_back(t);
  endfunction

  // Cycle in which requester w holds the grant; a=1 means a beat is acknowledged.
  function automatic void own(input logic [3:0] r, input logic o, input int w,
                              input logic v, input logic a);
    logic [3:0] g;
    g = 4'b0001 << w;
    add(1'b0, r, o, 1'b1, 1'b0, g, 2'(w), v, a ? g : 4'b0000, 1'b1);
  endfunction

  function automatic void idle(input logic [3:0] r, input logic o);
    add(1'b0, r, o, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
  endfunction

  // First cycle after reset: everything zero, sel included.
  function automatic void rst_state(input logic [3:0] r);
    add(1'b0, r, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
  endfunction

  task automatic check(input int row, input string nm, input logic [3:0] got,
                       input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL row %0d %s: got %b expected %b", row, nm, got, exp);
    end
  endtask

  int lat;
  int n_ack;
  int n_bub;

  initial begin
    reset     = 1'b1;
    req       = 4'b0000;
    out_ready = 1'b0;

    // Power-up reset, then single requester 2 taking one beat and withdrawing.
    add(1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    rst_state(4'b0000);
    idle(4'b0100, 1'b1);
    own(4'b0100, 1'b1, 2, 1'b1, 1'b1);
    own(4'b0000, 1'b1, 2, 1'b0, 1'b0);
    idle(4'b0000, 1'b1);

    // Reset to bring rr_ptr back to 0, then all four requesting: 0,1,2,3,0.
    add(1'b1, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    rst_state(4'b1111);
    for (int o = 0; o < 4; o++)
      for (int b = 0; b < 4; b++)
        own(4'b1111, 1'b1, o, 1'b1, 1'b1);
    own(4'b1111, 1'b1, 0, 1'b1, 1'b1);
    own(4'b0010, 1'b1, 0, 1'b0, 1'b0);

    // Owner 1 stalled 5 cycles, then 4 beats; waiting requester 0 must not preempt.
    for (int i = 0; i < 5; i++) own(4'b0011, 1'b0, 1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) own(4'b0011, 1'b1, 1, 1'b1, 1'b1);
    own(4'b0011, 1'b1, 0, 1'b1, 1'b1);
    own(4'b0000, 1'b1, 0, 1'b0, 1'b0);
    idle(4'b0000, 1'b1);

    // Requester 3 alone: burst, re-grant with no bubble, then pointer wraps to 0.
    idle(4'b1000, 1'b1);
    for (int i = 0; i < 7; i++) own(4'b1000, 1'b1, 3, 1'b1, 1'b1);
    own(4'b1001, 1'b1, 3, 1'b1, 1'b1);
    own(4'b1001, 1'b1, 0, 1'b1, 1'b1);

    // Owner 2 reset after 2 beats; the beat in the reset cycle gets no ack.
    own(4'b0100, 1'b1, 0, 1'b0, 1'b0);
    own(4'b0100, 1'b1, 2, 1'b1, 1'b1);
    own(4'b0100, 1'b1, 2, 1'b1, 1'b1);
    add(1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0, 4'b0000, 1'b1);
    rst_state(4'b0100);
    for (int i = 0; i < 3; i++) own(4'b0100, 1'b1, 2, 1'b1, 1'b1);
    own(4'b0101, 1'b1, 2, 1'b1, 1'b1);

    // Owner 0 withdraws while stalled; pending requester 3 takes over next cycle.
    own(4'b1001, 1'b0, 0, 1'b1, 1'b0);
    own(4'b1000, 1'b0, 0, 1'b0, 1'b0);
    own(4'b1000, 1'b1, 3, 1'b1, 1'b1);
    own(4'b0000, 1'b1, 3, 1'b0, 1'b0);
    idle(4'b0000, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      reset     = vecs[i].rst;
      req       = vecs[i].req;
      out_ready = vecs[i].ordy;
      @(negedge clk);
      if (vecs[i].chk) begin
        check(i, "gnt", gnt, vecs[i].gnt);
        check(i, "ack", ack, vecs[i].ack);
        check(i, "valid", {3'b000, valid}, {3'b000, vecs[i].valid});
        check(i, "busy", {3'b000, busy}, {3'b000, vecs[i].busy});
        if (!vecs[i].sel_dc) check(i, "sel", {2'b00, sel}, {2'b00, vecs[i].sel});
      end
    end

    // Grant latency from idle is one cycle, and a lone requester streams with no gaps.
    @(posedge clk);
    #1;
    req       = 4'b0010;
    out_ready = 1'b1;
    lat       = 0;
    while (lat < 8 && gnt !== 4'b0010) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check(-1, "grant_latency", 4'(lat), 4'd1);
    n_ack = 0;
    n_bub = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack === 4'b0010) n_ack++;
      if (valid !== 1'b1) n_bub++;
    end
    check(-1, "stream_acks", 4'(n_ack), 4'd12);
    check(-1, "stream_bubbles", 4'(n_bub), 4'd0);

    @(posedge clk);
    #1;
    req = 4'b0000;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
